// File: rtl/div_pkg.sv
// Shared divider types: FSM state encoding, default operand width, magnitude helper.
// The optional ovf output is enabled with the SEQ_DIVIDER_OVF_EN macro.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } div_state_e;

  // Magnitude of a zero-extended two's-complement value; callers truncate to their width.
  function automatic logic [32:0] twos_mag(input logic [32:0] v, input logic neg);
    return neg ? (33'd0 - v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {P,A} left, trial-subtract |divisor|, set the quotient bit.
// Purely combinational; the top-level FSM registers its outputs.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH:0]   d,
  output logic [WIDTH-1:0] p_nxt,
  output logic [WIDTH-1:0] a_nxt
);

  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] t;

  assign p_sh = {p, a[WIDTH-1]};
  // P < d before the shift, so the WIDTH+1-bit difference never wraps past its sign bit.
  assign t     = p_sh - d;
  assign p_nxt = t[WIDTH] ? p_sh[WIDTH-1:0] : t[WIDTH-1:0];
  assign a_nxt = {a[WIDTH-2:0], ~t[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Sequential signed/unsigned divider, one restoring step per clock; done WIDTH+1 clocks after start (1 on /0).
// start is accepted only in IDLE with done low; define SEQ_DIVIDER_OVF_EN to enable the MIN/-1 ovf flag.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero,
  output logic             ovf
);

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH:0]   dvs;
  logic             neg_q;
  logic             neg_r;
  logic             dz;

  logic             accept;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH:0]   dvs_mag;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] a_nxt;

  // The done cycle still counts as part of the operation, so start is not taken there.
  assign accept  = (state == IDLE) && start && !done;
  assign dvd_neg = signed_op & dividend[WIDTH-1];
  assign dvs_neg = signed_op & divisor[WIDTH-1];
  assign dvd_mag = WIDTH'(twos_mag(33'({dvd_neg, dividend}), dvd_neg));
  assign dvs_mag = (WIDTH + 1)'(twos_mag(33'({dvs_neg, divisor}), dvs_neg));

  div_step #(.WIDTH(WIDTH)) u_step (
    .p     (p),
    .a     (a),
    .d     (dvs),
    .p_nxt (p_nxt),
    .a_nxt (a_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      p        <= '0;
      a        <= '0;
      dvd      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd      <= dividend;
            dvs      <= dvs_mag;
            a        <= dvd_mag;
            p        <= '0;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            cnt      <= CNT_W'(WIDTH);
            busy     <= 1'b1;
            div_zero <= 1'b0;
            dz       <= (divisor == '0);
            state    <= (divisor == '0) ? FIN : CALC;
          end
        end
        CALC: begin
          p   <= p_nxt;
          a   <= a_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIN;
        end
        FIN: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= dz;
          state    <= IDLE;
          if (dz) begin
            quo <= '1;
            rem <= dvd;
          end else begin
            quo <= neg_q ? -a : a;
            rem <= neg_r ? -p : p;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_DIVIDER_OVF_EN
  logic ovf_q;

  // MIN / -1: dividend negative and equal to MIN, divisor negative with magnitude 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (state == FIN) begin
      ovf_q <= !dz && neg_r && (neg_q ^ neg_r) &&
               (dvd == {1'b1, {(WIDTH-1){1'b0}}}) && (dvs == (WIDTH + 1)'(1));
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider at WIDTH=8 with hand-computed results.
// Covers latency, busy window, signed/unsigned selection, /0, MIN/-1, ignored start and mid-op reset.
module tb_seq_divider;

  localparam int W = 8;
`ifdef SEQ_DIVIDER_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         div_zero;
  logic         ovf;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quo       (quo),
    .rem       (rem),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present operands for one edge; returns at the sample point just after the accepting edge.
  task automatic launch(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk); #1;
    start     = 1'b1;
    signed_op = s;
    dividend  = x;
    divisor   = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done (bounded), counting latency and busy cycles, then checks the result.
  task automatic finish(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eovf, input int elat, input logic poke);
    int lat;
    int nbusy;
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (poke && lat == 2) begin
        start     = 1'b1;
        signed_op = 1'b1;
        dividend  = 8'h55;
        divisor   = 8'h03;
      end
      if (poke && lat == 3) start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_busy"}, nbusy, elat);
    check({tag, "_quo"}, quo, eq);
    check({tag, "_rem"}, rem, er);
    check({tag, "_dz"}, div_zero, edz);
    check({tag, "_ovf"}, ovf, eovf);
  endtask

  initial begin
    int ndone;
    rst_n     = 1'b0;
    start     = 1'b0;
    signed_op = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #23;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quo", quo, 0);
    check("rst_rem", rem, 0);
    check("rst_dz", div_zero, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    launch(1'b0, 8'h64, 8'h07);
    finish("u100_7", 8'h0E, 8'h02, 1'b0, 1'b0, 9, 1'b0);

    launch(1'b1, 8'hF9, 8'h02);
    finish("s_m7_2", 8'hFD, 8'hFF, 1'b0, 1'b0, 9, 1'b0);
    launch(1'b1, 8'h07, 8'hFE);
    finish("s_7_m2", 8'hFD, 8'h01, 1'b0, 1'b0, 9, 1'b0);
    launch(1'b0, 8'hF9, 8'h02);
    finish("u_f9_2", 8'h7C, 8'h01, 1'b0, 1'b0, 9, 1'b0);

    launch(1'b0, 8'h35, 8'h00);
    finish("dz", 8'hFF, 8'h35, 1'b1, 1'b0, 1, 1'b0);

    // start held through the done cycle must only be taken on the next IDLE cycle
    start     = 1'b1;
    signed_op = 1'b0;
    dividend  = 8'h09;
    divisor   = 8'h03;
    @(posedge clk); #1;
    check("b2b_ignored", busy, 0);
    check("b2b_done_pulse", done, 0);
    @(posedge clk); #1;
    start = 1'b0;
    finish("u9_3", 8'h03, 8'h00, 1'b0, 1'b0, 9, 1'b0);

    launch(1'b1, 8'h80, 8'hFF);
    finish("min_m1", 8'h80, 8'h00, 1'b0, OVF_EXP, 9, 1'b0);

    launch(1'b0, 8'hC8, 8'h0A);
    finish("ignore", 8'h14, 8'h00, 1'b0, 1'b0, 9, 1'b1);

    launch(1'b0, 8'h64, 8'h07);
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quo", quo, 0);
    check("abort_rem", rem, 0);
    #2;
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 0);

    launch(1'b0, 8'h2D, 8'h04);
    finish("after_rst", 8'h0B, 8'h01, 1'b0, 1'b0, 9, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
